// File: rtl/pcx_iq_pkg.sv
// Shared sizing constants for the PCX input-queue buffer on the L2 side of the crossbar.
package pcx_iq_pkg;

    localparam int PCX_WIDTH       = 124;
    localparam int PCX_IQ_DEPTH    = 16;
    localparam int PCX_IQ_HEADROOM = 3;
    localparam int PCX_IQ_PW       = $clog2(PCX_IQ_DEPTH) + 1;

endpackage

// File: rtl/pcx_iq_ram.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port, no reset.
module pcx_iq_ram
    import pcx_iq_pkg::*;
#(
    parameter int WIDTH = PCX_WIDTH,
    parameter int DEPTH = PCX_IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pcx_iq_buf.sv
// PCX input-queue buffer: in-order circular buffer after PX2 with registered back-pressure
// to the crossbar arbiter and a sticky overflow flag.
module pcx_iq_buf
    import pcx_iq_pkg::*;
#(
    parameter int WIDTH    = PCX_WIDTH,
    parameter int DEPTH    = PCX_IQ_DEPTH,
    parameter int HEADROOM = PCX_IQ_HEADROOM
) (
    input  logic                   rclk,
    input  logic                   arst_l,
    input  logic [WIDTH-1:0]       pcx_data_px2,
    input  logic                   pcx_data_rdy_px2,
    output logic                   pcx_stall_pq,
    output logic                   iq_vld,
    output logic [WIDTH-1:0]       iq_data,
    input  logic                   iq_pop,
    output logic [$clog2(DEPTH):0] iq_cnt,
    output logic                   iq_ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] STALL_THR = PW'(DEPTH - HEADROOM);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          stall_q, stall_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] cnt, cnt_nxt;
    logic          empty, full, push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign cnt   = wr_ptr_q - rd_ptr_q;

    // A pop on a full buffer frees the slot the simultaneous push lands in.
    assign pop_ok  = iq_pop && !empty;
    assign push_ok = pcx_data_rdy_px2 && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_nxt  = cnt;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_nxt = cnt + PW'(1);
            2'b01:   cnt_nxt = cnt - PW'(1);
            default: cnt_nxt = cnt;
        endcase
        stall_d = (cnt_nxt >= STALL_THR);
        ovf_d   = ovf_q || (pcx_data_rdy_px2 && full && !pop_ok);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    pcx_iq_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (rclk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (pcx_data_px2),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (iq_data)
    );

    assign iq_vld       = !empty;
    assign iq_cnt       = cnt;
    assign pcx_stall_pq = stall_q;
    assign iq_ovf_err   = ovf_q;

endmodule

// File: tb/tb_pcx_iq_buf.sv
// Self-checking bench for pcx_iq_buf: directed scenarios plus randomized traffic against a queue model.
module tb_pcx_iq_buf;
    import pcx_iq_pkg::*;

    localparam int WIDTH    = PCX_WIDTH;
    localparam int DEPTH    = PCX_IQ_DEPTH;
    localparam int HEADROOM = PCX_IQ_HEADROOM;

    logic                   rclk = 1'b0;
    logic                   arst_l;
    logic [WIDTH-1:0]       pcx_data_px2;
    logic                   pcx_data_rdy_px2;
    logic                   pcx_stall_pq;
    logic                   iq_vld;
    logic [WIDTH-1:0]       iq_data;
    logic                   iq_pop;
    logic [$clog2(DEPTH):0] iq_cnt;
    logic                   iq_ovf_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    int               max_cnt;

    pcx_iq_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
        .rclk             (rclk),
        .arst_l           (arst_l),
        .pcx_data_px2     (pcx_data_px2),
        .pcx_data_rdy_px2 (pcx_data_rdy_px2),
        .pcx_stall_pq     (pcx_stall_pq),
        .iq_vld           (iq_vld),
        .iq_data          (iq_data),
        .iq_pop           (iq_pop),
        .iq_cnt           (iq_cnt),
        .iq_ovf_err       (iq_ovf_err)
    );

    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_pkt();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[WIDTH-1:0];
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".vld"},   128'(iq_vld),       128'(m_q.size() != 0));
        check_eq({tag, ".cnt"},   128'(iq_cnt),       128'(m_q.size()));
        check_eq({tag, ".stall"}, 128'(pcx_stall_pq), 128'(m_q.size() >= DEPTH - HEADROOM));
        check_eq({tag, ".ovf"},   128'(iq_ovf_err),   128'(m_ovf));
        if (m_q.size() != 0) begin
            check_eq({tag, ".data"}, 128'(iq_data), 128'(m_q[0]));
        end
    endtask

    // One clock: present inputs, let the edge happen, apply queue semantics, compare.
    task automatic step(input string tag, input logic push, input logic [WIDTH-1:0] d, input logic pop);
        bit pop_ok, push_ok;
        pcx_data_rdy_px2 = push;
        pcx_data_px2     = d;
        iq_pop           = pop;
        @(posedge rclk);
        #1;
        pop_ok  = pop && (m_q.size() > 0);
        push_ok = push && ((m_q.size() < DEPTH) || pop_ok);
        if (push && !push_ok) m_ovf = 1'b1;
        if (pop_ok) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(d);
        if (m_q.size() > max_cnt) max_cnt = m_q.size();
        pcx_data_rdy_px2 = 1'b0;
        iq_pop           = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2;
        arst_l = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        check_all("rst_async");
        @(posedge rclk);
        @(negedge rclk);
        arst_l = 1'b1;
        @(posedge rclk);
        #1;
    endtask

    initial begin
        arst_l           = 1'b0;
        pcx_data_px2     = '0;
        pcx_data_rdy_px2 = 1'b0;
        iq_pop           = 1'b0;
        m_ovf            = 1'b0;
        max_cnt          = 0;
        #12;
        check_all("reset");
        @(negedge rclk);
        arst_l = 1'b1;
        repeat (3) step("idle", 1'b0, '0, 1'b0);

        // In-order read-out of three packets
        step("p1", 1'b1, WIDTH'(1), 1'b0);
        step("p2", 1'b1, WIDTH'(2), 1'b0);
        step("p3", 1'b1, WIDTH'(3), 1'b0);
        check_eq("cnt_after3", 128'(iq_cnt), 128'(3));
        check_eq("head_1", 128'(iq_data), 128'(1));
        step("pop1", 1'b0, '0, 1'b1);
        check_eq("head_2", 128'(iq_data), 128'(2));
        step("pop2", 1'b0, '0, 1'b1);
        check_eq("head_3", 128'(iq_data), 128'(3));
        step("pop3", 1'b0, '0, 1'b1);
        check_eq("vld_drop", 128'(iq_vld), 128'(0));
        step("pop_empty", 1'b0, '0, 1'b1);

        // Fill to the stall threshold, then to full, then overflow
        for (int i = 0; i < 12; i++) step("fill", 1'b1, WIDTH'(16'h100 + i), 1'b0);
        check_eq("stall_at12", 128'(pcx_stall_pq), 128'(0));
        step("fill13", 1'b1, WIDTH'(16'h10c), 1'b0);
        check_eq("stall_at13", 128'(pcx_stall_pq), 128'(1));
        for (int i = 13; i < 16; i++) step("fill", 1'b1, WIDTH'(16'h100 + i), 1'b0);
        check_eq("cnt_full", 128'(iq_cnt), 128'(16));
        check_eq("no_ovf_full", 128'(iq_ovf_err), 128'(0));
        step("push17", 1'b1, WIDTH'(16'hdead), 1'b0);
        check_eq("ovf_set", 128'(iq_ovf_err), 128'(1));
        check_eq("cnt_stays16", 128'(iq_cnt), 128'(16));
        step("ovf_sticky", 1'b0, '0, 1'b1);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < 16; i++) step("refill", 1'b1, WIDTH'(16'h200 + i), 1'b0);
        step("full_pp", 1'b1, WIDTH'(16'h2ff), 1'b1);
        check_eq("full_pp_cnt", 128'(iq_cnt), 128'(16));
        check_eq("full_pp_head", 128'(iq_data), 128'(16'h201));
        check_eq("full_pp_ovf", 128'(iq_ovf_err), 128'(0));
        for (int i = 0; i < 15; i++) step("drain", 1'b0, '0, 1'b1);
        check_eq("last_is_new", 128'(iq_data), 128'(16'h2ff));
        step("drain_last", 1'b0, '0, 1'b1);

        // Streaming across pointer wrap
        max_cnt = 0;
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, WIDTH'(32'h1000 + i), 1'b1);
        step("wrap_end", 1'b0, '0, 1'b1);
        check_eq("wrap_maxcnt", 128'(max_cnt), 128'(1));

        // Randomized traffic with shifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            int pp;
            pp = (i / 100) % 3 == 0 ? 80 : ((i / 100) % 3 == 1 ? 50 : 25);
            step("rand", ($urandom_range(99) < pp), rnd_pkt(), ($urandom_range(99) < 100 - pp));
        end

        // Asynchronous reset with entries queued
        do_reset();
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, rnd_pkt(), 1'b0);
        check_eq("pre_rst_cnt", 128'(iq_cnt), 128'(5));
        do_reset();
        step("post_rst", 1'b1, WIDTH'(8'ha5), 1'b0);
        check_eq("post_rst_head", 128'(iq_data), 128'(8'ha5));
        check_eq("post_rst_cnt", 128'(iq_cnt), 128'(1));
        check_eq("post_rst_wrptr", 128'(dut.wr_ptr_q), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
